// File: rtl/button_event_pkg.sv
// Shared types and default timing constants for the button gesture decoder.
// Default tick counts assume a 50 MHz clock (250 ms long press, 125 ms double gap, 50 ms repeat).
package button_event_pkg;

  localparam int unsigned DEF_LONG_TICKS   = 12_500_000;
  localparam int unsigned DEF_DOUBLE_TICKS = 6_250_000;
  localparam int unsigned DEF_REPEAT_TICKS = 2_500_000;
  localparam int unsigned DEF_TIMER_W      = 24;

  typedef enum logic [2:0] {
    ST_IDLE           = 3'd0,
    ST_PRESSED        = 3'd1,
    ST_LONG_HELD      = 3'd2,
    ST_WAIT_SECOND    = 3'd3,
    ST_SECOND_PRESSED = 3'd4
  } btn_evt_state_t;

  // States in which the user is physically holding the button.
  function automatic logic is_held_state(input btn_evt_state_t s);
    return (s == ST_PRESSED) || (s == ST_LONG_HELD) || (s == ST_SECOND_PRESSED);
  endfunction

endpackage

// File: rtl/level_edge_detect.sv
// Turns a synchronous level into single-cycle press/release strobes.
// The strobes are combinational so the consumer sees them in the same cycle as the level change.
module level_edge_detect #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic level,
  output logic press_evt,
  output logic rel_evt
);

  logic pressed;
  logic prev_d;
  logic prev_q;

  assign pressed = level ^ ACTIVE_LOW;

  always_comb begin
    prev_d = pressed;
  end

  // Clearing prev on reset makes a button held through reset look like a fresh press.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign press_evt = pressed & ~prev_q;
  assign rel_evt   = ~pressed & prev_q;

endmodule

// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into short, long, double and auto-repeat pulses.
// All outputs are registered; each pulse lasts exactly one CLK cycle.
module button_event_decoder
  import button_event_pkg::*;
#(
  parameter bit          ACTIVE_LOW   = 1'b0,
  parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS,
  parameter int unsigned DOUBLE_TICKS = DEF_DOUBLE_TICKS,
  parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter int unsigned TIMER_W      = DEF_TIMER_W
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn_state,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic repeat_pulse,
  output logic held
);

  localparam logic [TIMER_W-1:0] LONG_LAST   = TIMER_W'(LONG_TICKS - 1);
  localparam logic [TIMER_W-1:0] DOUBLE_LAST = TIMER_W'(DOUBLE_TICKS - 1);
  localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_TICKS - 1);

  logic press_evt;
  logic rel_evt;

  btn_evt_state_t     state_d, state_q;
  logic [TIMER_W-1:0] timer_d, timer_q;
  logic               short_press_d, short_press_q;
  logic               long_press_d, long_press_q;
  logic               double_press_d, double_press_q;
  logic               repeat_pulse_d, repeat_pulse_q;
  logic               held_d, held_q;

  level_edge_detect #(
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_edge (
    .CLK       (CLK),
    .RST       (RST),
    .level     (btn_state),
    .press_evt (press_evt),
    .rel_evt   (rel_evt)
  );

  // Release and press events are tested before the timeouts so they win any coincidence.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
    state_d        = state_q;
    timer_d        = timer_q + TIMER_W'(1);
    short_press_d  = 1'b0;
    long_press_d   = 1'b0;
    double_press_d = 1'b0;
    repeat_pulse_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (press_evt) state_d = ST_PRESSED;
      end
      ST_PRESSED: begin
        if (rel_evt) begin
          state_d = ST_WAIT_SECOND;
        end else if (timer_q == LONG_LAST) begin
          state_d      = ST_LONG_HELD;
          long_press_d = 1'b1;
        end
      end
      ST_LONG_HELD: begin
        if (rel_evt) begin
          state_d = ST_IDLE;
        end else if (timer_q == REPEAT_LAST) begin
          timer_d        = '0;
          repeat_pulse_d = 1'b1;
        end
      end
      ST_WAIT_SECOND: begin
        if (press_evt) begin
          state_d        = ST_SECOND_PRESSED;
          double_press_d = 1'b1;
        end else if (timer_q == DOUBLE_LAST) begin
          state_d       = ST_IDLE;
          short_press_d = 1'b1;
        end
      end
      ST_SECOND_PRESSED: begin
        timer_d = '0;
        if (rel_evt) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase

    if (state_d != state_q) timer_d = '0;

    // held tracks the state being entered, so it rises on the same edge as the press.
    held_d = is_held_state(state_d);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      short_press_q  <= 1'b0;
      long_press_q   <= 1'b0;
      double_press_q <= 1'b0;
      repeat_pulse_q <= 1'b0;
      held_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values computed above.
      state_q        <= state_d;
      timer_q        <= timer_d;
      short_press_q  <= short_press_d;
      long_press_q   <= long_press_d;
      double_press_q <= double_press_d;
      repeat_pulse_q <= repeat_pulse_d;
      held_q         <= held_d;
    end
  end

  assign short_press  = short_press_q;
  assign long_press   = long_press_q;
  assign double_press = double_press_q;
  assign repeat_pulse = repeat_pulse_q;
  assign held         = held_q;

endmodule
